// File: rtl/cpu15_pkg.sv
// cpu15_pkg: shared opcodes, sequencer states and instruction field positions
package cpu15_pkg;
  localparam int DATA_W  = 16;
  localparam int REG_N   = 8;
  localparam int INSTR_W = 15;
  localparam int OPC_HI  = 14;
  localparam int OPC_LO  = 11;
  localparam int RA_HI   = 10;
  localparam int RA_LO   = 8;
  localparam int RB_HI   = 7;
  localparam int RB_LO   = 5;
  localparam int IMM_HI  = 7;
  localparam int IMM_LO  = 0;
  localparam logic [3:0] OP_MOV = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_LDL = 4'h8;
  localparam logic [3:0] OP_LDH = 4'h9;
  localparam logic [3:0] OP_CMP = 4'ha;
  localparam logic [3:0] OP_JE  = 4'hb;
  localparam logic [3:0] OP_JMP = 4'hc;
  localparam logic [3:0] OP_LD  = 4'hd;
  localparam logic [3:0] OP_ST  = 4'he;
  localparam logic [3:0] OP_HLT = 4'hf;
  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;
  function automatic logic [3:0] ir_opc(input logic [INSTR_W-1:0] ir);
    return ir[OPC_HI:OPC_LO];
  endfunction
endpackage

// File: rtl/regfile8x16.sv
// regfile8x16: two combinational read ports, one synchronous write port, synchronous clear
module regfile8x16 #(
  parameter int DATA_W = 16,
  parameter int REG_N  = 8
) (
  input  logic                     CLK_EX,
  input  logic                     clr,
  input  logic                     wen,
  input  logic [$clog2(REG_N)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(REG_N)-1:0] ra_addr,
  input  logic [$clog2(REG_N)-1:0] rb_addr,
  output logic [DATA_W-1:0]        ra_data,
  output logic [DATA_W-1:0]        rb_data
);
  logic [DATA_W-1:0] rf [REG_N];
  // clear has priority so a write on the reset edge is dropped
  always_ff @(posedge CLK_EX) begin
    if (clr) begin
      for (int i = 0; i < REG_N; i++) rf[i] <= '0;
    end else if (wen) begin
      rf[waddr] <= wdata;
    end
  end
  assign ra_data = rf[ra_addr];
  assign rb_data = rf[rb_addr];
endmodule

// File: rtl/decode_regfile.sv
// decode_regfile: 4-phase fetch/decode sequencer, IR, bubble mux and register file write-back
module decode_regfile #(
  parameter int DATA_W = cpu15_pkg::DATA_W,
  parameter int REG_N  = cpu15_pkg::REG_N
) (
  input  logic              CLK_EX,
  input  logic              RESET_N,
  input  logic [7:0]        P_COUNT,
  output logic [7:0]        ROM_ADDR,
  input  logic [14:0]       ROM_DATA,
  input  logic [DATA_W-1:0] REG_IN,
  input  logic              REG_WEN,
  output logic [3:0]        OP_CODE,
  output logic [DATA_W-1:0] REG_A,
  output logic [DATA_W-1:0] REG_B,
  output logic [7:0]        OP_DATA,
  output logic [7:0]        RAM_ADDR,
  output logic [1:0]        PHASE,
  output logic              HALTED
);
  import cpu15_pkg::*;
  state_t state, state_nxt;
  logic halted_nxt;
  logic [INSTR_W-1:0] ir;
  // sequencer state, halt flag and instruction register
  always_ff @(posedge CLK_EX) begin
    if (!RESET_N) begin
      state  <= ST_FETCH;
      HALTED <= 1'b0;
      ir     <= '0;
    end else begin
      state  <= state_nxt;
      HALTED <= halted_nxt;
      if (state == ST_DECODE) ir <= ROM_DATA;
    end
  end
  // EXEC always steps to WB, so a halt parks the sequencer with PHASE reading 3
  always_comb begin
    state_nxt  = HALTED ? state : state_t'(state + 2'd1);
    halted_nxt = HALTED | (state == ST_EXEC && ir_opc(ir) == OP_HLT);
  end
  assign ROM_ADDR = P_COUNT;
  assign PHASE    = state;
  assign OP_CODE  = (state == ST_EXEC && !HALTED) ? ir_opc(ir) : OP_HLT;
  assign OP_DATA  = ir[IMM_HI:IMM_LO];
  assign RAM_ADDR = ir[IMM_HI:IMM_LO];
  regfile8x16 #(.DATA_W(DATA_W), .REG_N(REG_N)) u_rf (
    .CLK_EX  (CLK_EX),
    .clr     (!RESET_N),
    .wen     (state == ST_WB && !HALTED && REG_WEN),
    .waddr   (ir[RA_HI:RA_LO]),
    .wdata   (REG_IN),
    .ra_addr (ir[RA_HI:RA_LO]),
    .rb_addr (ir[RB_HI:RB_LO]),
    .ra_data (REG_A),
    .rb_data (REG_B)
  );
endmodule

// File: doc/decode_regfile.md
# decode_regfile

Instruction decode and register-file block that sits on the opposite side of the execute stage's interface. It fetches the 15-bit instruction addressed by `P_COUNT` from the instruction ROM. It decodes the instruction into `OP_CODE` / `REG_A` / `REG_B` / `OP_DATA` for the execute stage. It writes the execute stage's `REG_IN` result back into an 8×16 register file. A 4-phase sequencer paces each instruction and feeds `HLT` bubbles to the execute stage outside its EXEC phase.

## Interface
Parameters:
- `DATA_W`, 16, register and data width
- `REG_N`, 8, number of general registers (index width 3)

Ports:
- `CLK_EX`  in  1  clock; all state changes on rising edge
- `RESET_N`  in  1  reset, synchronous, active-low
- `P_COUNT`  in  8  program counter from execute stage
- `ROM_ADDR`  out  8  instruction ROM address; equals `P_COUNT` combinationally
- `ROM_DATA`  in  15  ROM read data, valid one cycle after address is sampled
- `REG_IN`  in  16  write-back data from execute stage
- `REG_WEN`  in  1  write-back enable from execute stage
- `OP_CODE`  out  4  opcode to execute stage (`4'hf` outside EXEC)
- `REG_A`  out  16  `rf[IR[10:8]]`
- `REG_B`  out  16  `rf[IR[7:5]]`
- `OP_DATA`  out  8  `IR[7:0]`
- `RAM_ADDR`  out  8  data RAM address, `IR[7:0]`, held for all phases
- `PHASE`  out  2  current sequencer state encoding
- `HALTED`  out  1  high in HALT state

## Operation
- Instruction format: `[14:11]` opcode, `[10:8]` A/destination index, `[7:5]` B index, `[7:0]` immediate/address.
- States are encoded as: FETCH=0, DECODE=1, EXEC=2, WB=3, HALT (separate flag, `PHASE` holds 3).
- FETCH → DECODE: the ROM samples `ROM_ADDR` at the end of FETCH.
- DECODE → EXEC: at the end of DECODE, IR <= `ROM_DATA`.
- EXEC: `OP_CODE` = `IR[14:11]`. If that value is `4'hf`, the next state is HALT; otherwise it is WB.
- WB: `OP_CODE` = `4'hf`. If `REG_WEN`=1, then `rf[IR[10:8]]` <= `REG_IN` at the end of WB. Next state is FETCH.
- HALT: `OP_CODE` = `4'hf` and `HALTED`=1. The block stays in HALT until reset.
- `OP_CODE` is combinational: `(state==EXEC) ? IR[14:11] : 4'hf`. The execute stage therefore sees at most one real opcode per instruction, and its pc advances once.
- `REG_A`, `REG_B`, `OP_DATA` and `RAM_ADDR` are combinational from IR and the register file. They are stable from DECODE exit through WB.
- Register write is 16-bit full width with no masking. All register indices are in range, so there is no out-of-range case.
- `REG_WEN` is ignored outside WB.

## Timing
- Each instruction takes exactly 4 cycles (FETCH, DECODE, EXEC, WB). CPI = 4.
- The execute stage registers its result at the EXEC→WB edge. `REG_IN` / `REG_WEN` are sampled at the WB→FETCH edge.
- A write-back is visible on `REG_A` / `REG_B` from the next instruction's DECODE→EXEC onward. No forwarding is needed.
- The pc update at the EXEC edge is visible in the following FETCH, including for jumps.
- Reset (`RESET_N`=0 at an edge) has the following effect:
  - state <= FETCH, IR <= 0, all `rf` <= 0, `HALTED` <= 0
  - `OP_CODE` = `4'hf`, `PHASE` = 0
  - `REG_A` = `REG_B` = 0, `OP_DATA` = `RAM_ADDR` = 0
- Reset mid-instruction, in any state including HALT, abandons the instruction. Any WB write pending on that same edge is dropped: reset wins.
- `ROM_DATA` is don't-care outside DECODE.

## Structure
- Shared package `cpu15_pkg`:
  - opcode constants `OP_MOV`..`OP_HLT` (`4'h0`..`4'hf`)
  - state enum/constants
  - instruction field slice positions
  - `DATA_W`
- One sub-module: `regfile8x16`. It has 2 combinational read ports and 1 synchronous write port with synchronous clear.
- Sequencer, IR and bubble mux live in `decode_regfile`.

## Test plan
- Reset then hold: `PHASE` = 0, `OP_CODE` = f, `REG_A` = 0, `HALTED` = 0. After release, `PHASE` cycles 0,1,2,3,0.
- ROM[0]=LDL r1,#0x34 (`15'h4134`); bench exec returns `REG_IN`=`16'h0034`, `REG_WEN`=1 in WB → at the next EXEC, with IR addressing r1, `REG_A`=`16'h0034`. `OP_CODE`=8 is present only in cycle 2.
- ADD r2,r1 (`15'h0A20`) with r1=5, r2=7: during EXEC `REG_A`=7, `REG_B`=5 and `OP_CODE`=1; all other cycles show `OP_CODE`=f.
- `REG_WEN`=1 asserted outside WB with `REG_IN`=`16'hBEEF` → no register changes.
- ROM word `15'h7800` (HLT) → after EXEC, `HALTED`=1 and `OP_CODE`=f indefinitely; `RESET_N` low for one edge → `PHASE`=0 and `HALTED`=0.
- `RESET_N` low in WB with `REG_WEN`=1 and `REG_IN`=`16'h1234` → destination register reads 0 afterwards.
